// File: rtl/gumnut_pkg.sv
// Shared types and defaults for the Gumnut program-counter sequencer.
package gumnut_pkg;

  typedef logic [11:0] addr_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_RET   = 2'd2,
    S_INT   = 2'd3
  } state_t;

  localparam addr_t DEF_RESET_VEC = 12'h000;
  localparam addr_t DEF_INT_VEC   = 12'h001;

  // Return-address stack depth tracked by the sequencer.
  localparam logic [3:0] STK_MAX = 4'd8;

  // Sequential successor; wraps 12'hFFF -> 12'h000.
  function automatic addr_t pc_inc(input addr_t pc);
    return pc + 12'd1;
  endfunction

endpackage

// File: rtl/stk_depth_ctr.sv
// Shadow depth counter for the external return-address stack.
// Saturates at 0 and STK_MAX; any push at full or pop at empty latches err_o.
module stk_depth_ctr
  import gumnut_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cen_i,
  input  logic push_i,
  input  logic pop_i,
  output logic err_o
);

  logic [3:0] depth_q, depth_d;
  logic       err_q, err_d;

  // Next depth with saturation; the error flag is sticky until reset.
  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (push_i) begin
      if (depth_q == STK_MAX) err_d = 1'b1;
      else                    depth_d = depth_q + 4'd1;
    end else if (pop_i) begin
      if (depth_q == 4'd0) err_d = 1'b1;
      else                 depth_d = depth_q - 4'd1;
    end
  end

  // Depth and error registers, advanced only on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= 4'd0;
      err_q   <= 1'b0;
    end else if (cen_i) begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute control flow, call/return and
// single-level interrupt entry for the Gumnut core.
//
// state   | meaning
// S_FETCH | inst_req_o high, waiting for inst_ack_i
// S_EXEC  | resolve next PC (held while stall_i)
// S_RET   | stk_pop_o high, load popped address from stk_pc_i
// S_INT   | int_ack_o high, enter INT_VEC with interrupts disabled
//
// Strobes are registered: they are high during the cycle after the
// S_EXEC decision, so stk_pc_o is registered alongside stk_push_o.
// A ret instruction never takes an interrupt; its next PC is only known
// in S_RET.
module pc_sequencer
  import gumnut_pkg::*;
#(
  parameter logic [11:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [11:0] INT_VEC   = DEF_INT_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen_i,
  input  logic        inst_ack_i,
  input  logic        stall_i,
  input  logic        jmp_i,
  input  logic        jsb_i,
  input  logic        ret_i,
  input  logic        reti_i,
  input  logic        br_taken_i,
  input  logic        enai_i,
  input  logic        disi_i,
  input  logic [11:0] target_i,
  input  logic        int_req_i,
  input  logic [11:0] stk_pc_i,
  output logic [11:0] pc_o,
  output logic        inst_req_o,
  output logic        stk_push_o,
  output logic        stk_pop_o,
  output logic [11:0] stk_pc_o,
  output logic        int_ack_o,
  output logic        stk_err_o
);

  state_t state_q, state_d;
  addr_t  pc_q, pc_d;
  addr_t  saved_pc_q, saved_pc_d;
  addr_t  stk_pc_q, stk_pc_d;
  logic   int_en_q, int_en_d;
  logic   push_q, push_d;
  logic   pop_q, pop_d;
  logic   ack_q, ack_d;
  addr_t  next_pc;
  logic   int_take;

  // Next-state, next-PC and strobe decisions for the enabled edge.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    stk_pc_d   = stk_pc_q;
    int_en_d   = int_en_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    ack_d      = 1'b0;
    next_pc    = pc_inc(pc_q);
    int_take   = 1'b0;
    case (state_q)
      S_FETCH: if (inst_ack_i) state_d = S_EXEC;
      S_EXEC: begin
        if (!stall_i) begin
          if (reti_i) begin
            next_pc = saved_pc_q;
          end else if (ret_i) begin
            pop_d = 1'b1;
          end else if (jsb_i) begin
            push_d   = 1'b1;
            stk_pc_d = pc_inc(pc_q);
            next_pc  = target_i;
          end else if (jmp_i || br_taken_i) begin
            next_pc = target_i;
          end
          if (reti_i || enai_i) int_en_d = 1'b1;
          if (disi_i)           int_en_d = 1'b0;
          int_take = int_en_q && int_req_i && !reti_i && !enai_i && !pop_d;
          if (pop_d) begin
            state_d = S_RET;
          end else if (int_take) begin
            saved_pc_d = next_pc;
            pc_d       = next_pc;
            ack_d      = 1'b1;
            state_d    = S_INT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_RET: begin
        pc_d    = stk_pc_i;
        state_d = S_FETCH;
      end
      S_INT: begin
        int_en_d = 1'b0;
        pc_d     = INT_VEC;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // FSM and registered outputs; everything holds while cen_i is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_VEC;
      saved_pc_q <= 12'h000;
      stk_pc_q   <= 12'h000;
      int_en_q   <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else if (cen_i) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      stk_pc_q   <= stk_pc_d;
      int_en_q   <= int_en_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      ack_q      <= ack_d;
    end
  end

  stk_depth_ctr u_depth (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen_i  (cen_i),
    .push_i (push_d),
    .pop_i  (pop_d),
    .err_o  (stk_err_o)
  );

  assign pc_o       = pc_q;
  assign inst_req_o = (state_q == S_FETCH);
  assign stk_push_o = push_q;
  assign stk_pop_o  = pop_q;
  assign stk_pc_o   = stk_pc_q;
  assign int_ack_o  = ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner
// sequences and a random instruction stream against an instruction-level
// model of the control-flow rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, cen_i, inst_ack_i, stall_i;
  logic        jmp_i, jsb_i, ret_i, reti_i, br_taken_i, enai_i, disi_i;
  logic        int_req_i;
  logic [11:0] target_i, stk_pc_i;
  logic [11:0] pc_o, stk_pc_o;
  logic        inst_req_o, stk_push_o, stk_pop_o, int_ack_o, stk_err_o;

  int errors = 0;
  int checks = 0;
  bit rand_cen = 1'b0;

  typedef struct packed {
    logic jmp, jsb, ret, reti, br, enai, disi;
  } ctl_t;

  localparam ctl_t C_NONE = 7'b0000000;
  localparam ctl_t C_JMP  = 7'b1000000;
  localparam ctl_t C_JSB  = 7'b0100000;
  localparam ctl_t C_RET  = 7'b0010000;
  localparam ctl_t C_RETI = 7'b0001000;
  localparam ctl_t C_BR   = 7'b0000100;
  localparam ctl_t C_ENAI = 7'b0000010;
  localparam ctl_t C_DISI = 7'b0000001;

  typedef struct {
    ctl_t        ctl;
    logic [11:0] tgt;
    logic        irq;
    logic [11:0] stkv;
    int          nst;
    logic [11:0] exp_pc;
    int          exp_push;
    int          exp_pop;
    int          exp_ack;
    logic [11:0] exp_pushv;
  } vec_t;

  vec_t tbl[$];

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen_i      (cen_i),
    .inst_ack_i (inst_ack_i),
    .stall_i    (stall_i),
    .jmp_i      (jmp_i),
    .jsb_i      (jsb_i),
    .ret_i      (ret_i),
    .reti_i     (reti_i),
    .br_taken_i (br_taken_i),
    .enai_i     (enai_i),
    .disi_i     (disi_i),
    .target_i   (target_i),
    .int_req_i  (int_req_i),
    .stk_pc_i   (stk_pc_i),
    .pc_o       (pc_o),
    .inst_req_o (inst_req_o),
    .stk_push_o (stk_push_o),
    .stk_pop_o  (stk_pop_o),
    .stk_pc_o   (stk_pc_o),
    .int_ack_o  (int_ack_o),
    .stk_err_o  (stk_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input ctl_t c, input logic [11:0] t, input logic irq,
                              input logic [11:0] s, input int n, input logic [11:0] pc,
                              input int pu, input int po, input int ak, input logic [11:0] pv);
    vec_t v;
    v.ctl = c; v.tgt = t; v.irq = irq; v.stkv = s; v.nst = n;
    v.exp_pc = pc; v.exp_push = pu; v.exp_pop = po; v.exp_ack = ak; v.exp_pushv = pv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ctl(input ctl_t c);
    {jmp_i, jsb_i, ret_i, reti_i, br_taken_i, enai_i, disi_i} = c;
  endtask

  // One cen-disabled cycle with scrambled inputs; every output must hold.
  task automatic freeze();
    logic [28:0] snap;
    logic [9:0]  sav;
    logic [11:0] sav_t, sav_s;
    snap  = {pc_o, stk_pc_o, inst_req_o, stk_push_o, stk_pop_o, int_ack_o, stk_err_o};
    sav   = {inst_ack_i, stall_i, jmp_i, jsb_i, ret_i, reti_i, br_taken_i, enai_i, disi_i, int_req_i};
    sav_t = target_i;
    sav_s = stk_pc_i;
    cen_i = 1'b0;
    {inst_ack_i, stall_i, jmp_i, jsb_i, ret_i, reti_i, br_taken_i, enai_i, disi_i, int_req_i} = 10'($urandom);
    target_i = 12'($urandom);
    stk_pc_i = 12'($urandom);
    @(negedge clk);
    chk("cen_freeze", 32'({pc_o, stk_pc_o, inst_req_o, stk_push_o, stk_pop_o, int_ack_o, stk_err_o}),
        32'(snap));
    {inst_ack_i, stall_i, jmp_i, jsb_i, ret_i, reti_i, br_taken_i, enai_i, disi_i, int_req_i} = sav;
    target_i = sav_t;
    stk_pc_i = sav_s;
    cen_i = 1'b1;
  endtask

  task automatic cyc();
    if (rand_cen && $urandom_range(0, 3) == 0) freeze();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cen_i = 1'b1;
    inst_ack_i = 1'b0; stall_i = 1'b0; int_req_i = 1'b0;
    set_ctl(C_NONE);
    target_i = 12'h000; stk_pc_i = 12'h000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from S_FETCH and collects what the DUT did.
  task automatic do_instr(input ctl_t c, input logic [11:0] tgt, input logic irq,
                          input logic [11:0] stkv, input int nst, input int ackd,
                          output logic [11:0] pc_after, output int npush, output int npop,
                          output int nack, output logic [11:0] pushv);
    logic [11:0] pc0;
    bit done;
    pc0 = pc_o; npush = 0; npop = 0; nack = 0; pushv = 12'h000;
    chk("fetch_req", 32'(inst_req_o), 32'd1);
    inst_ack_i = 1'b0;
    for (int k = 0; k < ackd; k++) begin
      cyc();
      chk("fetch_wait", 32'({inst_req_o, pc_o}), 32'({1'b1, pc0}));
    end
    inst_ack_i = 1'b1;
    cyc();
    inst_ack_i = 1'b0;
    chk("exec_entry", 32'({inst_req_o, stk_push_o, stk_pop_o, int_ack_o, pc_o}), 32'({4'b0000, pc0}));
    set_ctl(c); target_i = tgt; int_req_i = irq; stk_pc_i = stkv; stall_i = 1'b1;
    for (int k = 0; k < nst; k++) begin
      cyc();
      chk("stall_hold", 32'({inst_req_o, stk_push_o, stk_pop_o, int_ack_o, pc_o}), 32'({4'b0000, pc0}));
    end
    stall_i = 1'b0;
    cyc();
    set_ctl(C_NONE);
    int_req_i = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 4 && !done; k++) begin
      if (stk_push_o) begin npush++; pushv = stk_pc_o; end
      if (stk_pop_o) npop++;
      if (int_ack_o) nack++;
      if (inst_req_o) done = 1'b1;
      else cyc();
    end
    chk("fetch_return", 32'(done), 32'd1);
    pc_after = pc_o;
  endtask

  // Instruction-level reference state.
  logic [11:0] m_pc, m_saved;
  logic        m_int_en, m_err;
  int          m_depth;
  logic [11:0] stk_q[$];

  initial begin
    logic [11:0] pa, pv, nxt, stkv, tgt, e_pc, e_pv;
    int npu, npo, nak, e_push, e_pop, nst, ackd;
    logic irq, take, new_en;
    ctl_t c;

    do_reset();
    chk("reset_state", 32'({pc_o, inst_req_o, stk_push_o, stk_pop_o, int_ack_o, stk_err_o, stk_pc_o}),
        32'({12'h000, 1'b1, 4'b0000, 12'h000}));

    // Directed table from reset.
    tbl.push_back(mk(C_NONE, 12'h000, 1'b0, 12'h000, 0, 12'h001, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_NONE, 12'h000, 1'b0, 12'h000, 1, 12'h002, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_JMP,  12'h010, 1'b0, 12'h000, 0, 12'h010, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_JSB,  12'h200, 1'b0, 12'h000, 1, 12'h200, 1, 0, 0, 12'h011));
    tbl.push_back(mk(C_RET,  12'h000, 1'b0, 12'h011, 0, 12'h011, 0, 1, 0, 12'h000));
    tbl.push_back(mk(C_JMP,  12'h020, 1'b0, 12'h000, 2, 12'h020, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_ENAI, 12'h000, 1'b0, 12'h000, 0, 12'h021, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_NONE, 12'h000, 1'b1, 12'h000, 1, 12'h001, 0, 0, 1, 12'h000));
    tbl.push_back(mk(C_RETI, 12'h000, 1'b0, 12'h000, 0, 12'h022, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_NONE, 12'h000, 1'b1, 12'h000, 0, 12'h001, 0, 0, 1, 12'h000));
    tbl.push_back(mk(ctl_t'(C_RETI | C_DISI), 12'h000, 1'b0, 12'h000, 0, 12'h023, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_NONE, 12'h000, 1'b1, 12'h000, 0, 12'h024, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_BR,   12'hFFF, 1'b0, 12'h000, 0, 12'hFFF, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_NONE, 12'h000, 1'b0, 12'h000, 0, 12'h000, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_JSB,  12'h100, 1'b0, 12'h000, 0, 12'h100, 1, 0, 0, 12'h001));
    tbl.push_back(mk(ctl_t'(C_RET | C_JSB | C_JMP), 12'h0AB, 1'b0, 12'h055, 0, 12'h055, 0, 1, 0, 12'h000));
    tbl.push_back(mk(ctl_t'(C_JSB | C_JMP), 12'h300, 1'b0, 12'h000, 3, 12'h300, 1, 0, 0, 12'h056));
    tbl.push_back(mk(ctl_t'(C_ENAI | C_DISI), 12'h000, 1'b0, 12'h000, 0, 12'h301, 0, 0, 0, 12'h000));
    tbl.push_back(mk(C_NONE, 12'h000, 1'b1, 12'h000, 0, 12'h302, 0, 0, 0, 12'h000));

    foreach (tbl[i]) begin
      do_instr(tbl[i].ctl, tbl[i].tgt, tbl[i].irq, tbl[i].stkv, tbl[i].nst, i % 3,
               pa, npu, npo, nak, pv);
      chk($sformatf("tbl%0d_pc", i), 32'(pa), 32'(tbl[i].exp_pc));
      chk($sformatf("tbl%0d_strobes", i), 32'({npu[3:0], npo[3:0], nak[3:0]}),
          32'({tbl[i].exp_push[3:0], tbl[i].exp_pop[3:0], tbl[i].exp_ack[3:0]}));
      if (tbl[i].exp_push != 0) chk($sformatf("tbl%0d_push_pc", i), 32'(pv), 32'(tbl[i].exp_pushv));
      chk($sformatf("tbl%0d_err", i), 32'(stk_err_o), 32'd0);
    end

    // Reset while a return is in flight, with a frozen S_RET first.
    do_instr(C_JMP, 12'h345, 1'b0, 12'h000, 0, 0, pa, npu, npo, nak, pv);
    chk("pre_ret_pc", 32'(pa), 32'h345);
    inst_ack_i = 1'b1;
    cyc();
    inst_ack_i = 1'b0;
    set_ctl(C_RET);
    stk_pc_i = 12'h777;
    cyc();
    set_ctl(C_NONE);
    chk("sret_pop", 32'({inst_req_o, stk_pop_o, pc_o}), 32'({1'b0, 1'b1, 12'h345}));
    freeze();
    freeze();
    #2 rst_n = 1'b0;
    #1 chk("rst_in_sret", 32'({pc_o, inst_req_o, stk_push_o, stk_pop_o, int_ack_o, stk_err_o}),
           32'({12'h000, 1'b1, 4'b0000}));
    @(negedge clk);
    chk("rst_hold", 32'({pc_o, inst_req_o, stk_pop_o}), 32'({12'h000, 1'b1, 1'b0}));
    rst_n = 1'b1;

    // Nine calls without a return: the ninth overflows.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      do_instr(C_JSB, 12'(k * 16), 1'b0, 12'h000, 0, 0, pa, npu, npo, nak, pv);
      chk($sformatf("ovf_push%0d", k), 32'({npu[3:0], pa}), 32'({4'd1, 12'(k * 16)}));
      chk($sformatf("ovf_err%0d", k), 32'(stk_err_o), 32'(k == 9));
    end
    do_instr(C_NONE, 12'h000, 1'b0, 12'h000, 0, 0, pa, npu, npo, nak, pv);
    chk("ovf_sticky", 32'(stk_err_o), 32'd1);

    // Return straight after reset underflows; the pop is still issued.
    do_reset();
    do_instr(C_RET, 12'h000, 1'b0, 12'h0AA, 1, 0, pa, npu, npo, nak, pv);
    chk("unf_pop", 32'({npo[3:0], pa}), 32'({4'd1, 12'h0AA}));
    chk("unf_err", 32'(stk_err_o), 32'd1);

    // Random instruction stream with random cen gaps.
    do_reset();
    rand_cen = 1'b1;
    m_pc = 12'h000; m_saved = 12'h000; m_int_en = 1'b0; m_err = 1'b0; m_depth = 0;
    stk_q.delete();
    for (int n = 0; n < 300; n++) begin
      c = C_NONE;
      c.jmp  = ($urandom_range(0, 5) == 0);
      c.jsb  = ($urandom_range(0, 4) == 0);
      c.ret  = ($urandom_range(0, (stk_q.size() > 0) ? 4 : 12) == 0);
      c.reti = ($urandom_range(0, 7) == 0);
      c.br   = ($urandom_range(0, 5) == 0);
      c.enai = ($urandom_range(0, 5) == 0);
      c.disi = ($urandom_range(0, 7) == 0);
      tgt  = 12'($urandom);
      irq  = ($urandom_range(0, 2) == 0);
      nst  = $urandom_range(0, 2);
      ackd = $urandom_range(0, 2);
      stkv = 12'($urandom);
      e_push = 0; e_pop = 0; e_pv = 12'h000;

      if (c.reti) begin
        nxt = m_saved;
      end else if (c.ret) begin
        e_pop = 1;
        if (stk_q.size() > 0) stkv = stk_q.pop_back();
        nxt = stkv;
        if (m_depth == 0) m_err = 1'b1; else m_depth--;
      end else if (c.jsb) begin
        e_push = 1;
        e_pv = m_pc + 12'd1;
        stk_q.push_back(e_pv);
        nxt = tgt;
        if (m_depth == 8) m_err = 1'b1; else m_depth++;
      end else if (c.jmp || c.br) begin
        nxt = tgt;
      end else begin
        nxt = m_pc + 12'd1;
      end

      take = m_int_en && irq && !c.reti && !c.enai && !c.ret;
      new_en = m_int_en;
      if (c.reti) new_en = 1'b1;
      if (c.disi) new_en = 1'b0;
      else if (c.enai) new_en = 1'b1;
      if (take) begin
        m_saved = nxt;
        new_en = 1'b0;
        e_pc = 12'h001;
      end else begin
        e_pc = nxt;
      end
      m_int_en = new_en;

      do_instr(c, tgt, irq, stkv, nst, ackd, pa, npu, npo, nak, pv);
      chk($sformatf("rnd%0d_pc", n), 32'(pa), 32'(e_pc));
      chk($sformatf("rnd%0d_strobes", n), 32'({npu[3:0], npo[3:0], nak[3:0]}),
          32'({4'(e_push), 4'(e_pop), 4'(take)}));
      if (e_push != 0) chk($sformatf("rnd%0d_push_pc", n), 32'(pv), 32'(e_pv));
      chk($sformatf("rnd%0d_err", n), 32'(stk_err_o), 32'(m_err));
      m_pc = e_pc;
    end
    rand_cen = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
